// File: rtl/conbus_arb.sv
// conbus_arb: NM-master / NS-slave data bus interconnect with one-cycle slave strobe.
// Latency: request sampled in cycle T, slave strobe in T+1, ack + read data in T+2; next grant T+3.
// Backpressure: masters hold m_req/m_a/m_we/m_do until m_ack; requests during an access wait in IDLE.
//
// Ports:
//   sys_clk, sys_rst      clock (rising edge), asynchronous active-low reset
//   m_req/m_we/m_a/m_do   per-master request, write enable, address, write data (packed by master)
//   m_ack/m_di            per-master one-cycle completion pulse and read data (valid with m_ack)
//   s_a/s_do/s_we         shared slave address and write data, one-hot slave write enable
//   s_di                  per-slave synchronous read data (packed by slave)
//
// Build option: define CONBUS_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest requesting master index wins).
module conbus_arb #(
    parameter int NM    = 2,
    parameter int SEL_W = 2,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NM-1:0]             m_req,
    input  logic [NM-1:0]             m_we,
    input  logic [NM*AW-1:0]          m_a,
    input  logic [NM*DW-1:0]          m_do,
    output logic [NM-1:0]             m_ack,
    output logic [NM*DW-1:0]          m_di,
    output logic [AW-1:0]             s_a,
    output logic [DW-1:0]             s_do,
    output logic [(2**SEL_W)-1:0]     s_we,
    input  logic [(2**SEL_W)*DW-1:0]  s_di
);

    localparam int NS = 2**SEL_W;
    localparam int OW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [AW-1:0]     s_a_q, s_a_d;
    logic [DW-1:0]     s_do_q, s_do_d;
    logic [NS-1:0]     s_we_q, s_we_d;
    logic [NM-1:0]     m_ack_q, m_ack_d;

    logic              gnt_vld;
    logic [OW-1:0]     gnt_idx;
    logic [OW-1:0]     cand;
    logic [AW-1:0]     gnt_a;
    logic [DW-1:0]     gnt_do;
    logic              gnt_we;
    logic [SEL_W-1:0]  gnt_sel;
    logic [DW-1:0]     rd_dat;

    // Arbitration: walk the masters in search order, first requester wins.
    // Round-robin starts one past the last owner; fixed priority starts at 0.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NM; k++) begin
`ifdef CONBUS_ARB_RR_EN
            cand = OW'((int'(last_q) + 1 + k) % NM);
`else
            cand = OW'(k);
`endif
            for (int j = 0; j < NM; j++) begin
                if (!gnt_vld && (OW'(j) == cand) && m_req[j]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

`ifndef CONBUS_ARB_RR_EN
    // last_q is kept in the fixed-priority build but has no reader.
    logic last_unused;
    assign last_unused = ^last_q;
`endif

    // Winner's request fields.
    always_comb begin
        gnt_a  = '0;
        gnt_do = '0;
        gnt_we = 1'b0;
        for (int j = 0; j < NM; j++) begin
            if (OW'(j) == gnt_idx) begin
                gnt_a  = m_a[j*AW +: AW];
                gnt_do = m_do[j*DW +: DW];
                gnt_we = m_we[j];
            end
        end
    end

    assign gnt_sel = gnt_a[AW-1 -: SEL_W];

    // Slave read data for the slave selected at grant time.
    always_comb begin
        rd_dat = '0;
        for (int s = 0; s < NS; s++) begin
            if (SEL_W'(s) == sel_q) begin
                rd_dat = s_di[s*DW +: DW];
            end
        end
    end

    // Read data reaches only the owner, and only in its ack cycle.
    always_comb begin
        m_di = '0;
        for (int j = 0; j < NM; j++) begin
            if ((state_q == DATA) && (owner_q == OW'(j))) begin
                m_di[j*DW +: DW] = rd_dat;
            end
        end
    end

    // Next-state and registered outputs. s_we and m_ack default to 0 so each
    // is a single-cycle pulse; s_a/s_do hold their last value.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        sel_d   = sel_q;
        s_a_d   = s_a_q;
        s_do_d  = s_do_q;
        s_we_d  = '0;
        m_ack_d = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    sel_d   = gnt_sel;
                    s_a_d   = gnt_a;
                    s_do_d  = gnt_do;
                    for (int s = 0; s < NS; s++) begin
                        s_we_d[s] = gnt_we && (gnt_sel == SEL_W'(s));
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                last_d = owner_q;
                for (int j = 0; j < NM; j++) begin
                    m_ack_d[j] = (owner_q == OW'(j));
                end
                state_d = DATA;
            end
            DATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NM - 1);
            sel_q   <= '0;
            s_a_q   <= '0;
            s_do_q  <= '0;
            s_we_q  <= '0;
            m_ack_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            s_a_q   <= s_a_d;
            s_do_q  <= s_do_d;
            s_we_q  <= s_we_d;
            m_ack_q <= m_ack_d;
        end
    end

    assign s_a   = s_a_q;
    assign s_do  = s_do_q;
    assign s_we  = s_we_q;
    assign m_ack = m_ack_q;

endmodule
